// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC decode-flow controller.
package ldpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_SWITCH,
    ST_WAIT
  } phase_state_t;

  localparam int unsigned LDPC_VNU_DELAY = 4;
  localparam int unsigned LDPC_CNU_DELAY = 6;
  localparam int unsigned LDPC_PHASES    = 36;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ldpc_frame_pending.sv
// Tracks whether a loaded frame is waiting to be consumed and flags overruns.
module ldpc_frame_pending (
  input  logic clk,
  input  logic reset,
  input  logic load_done,
  input  logic consume,
  output logic pending,
  output logic load_overrun
);

  // Pending flag: a load sets it, a consume clears it. When a consume takes
  // a frame whose load arrives in that very cycle, the flag ends clear,
  // because that load is the frame being consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= 1'b0;
      load_overrun <= 1'b0;
    end else begin
      load_overrun <= load_done & pending & ~consume;
      if (consume && !pending)
        pending <= 1'b0;
      else if (load_done)
        pending <= 1'b1;
      else if (consume)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/ldpc_phase_scheduler.sv
// Sequences one PE column through alternating VNU/CNU sweeps, drains and
// address-generator resets, counts phases per frame and ping-pongs the bank.
module ldpc_phase_scheduler
  import ldpc_pkg::*;
#(
  parameter int unsigned L          = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned VNU_DELAY  = LDPC_VNU_DELAY,
  parameter int unsigned CNU_DELAY  = LDPC_CNU_DELAY,
  parameter int unsigned PHASES     = LDPC_PHASES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       load_done,
  output logic                       enable,
  output logic                       vnu_en,
  output logic                       ag_reset,
  output logic                       extended,
  output logic [ADDR_WIDTH-1:0]      sweep_addr,
  output logic                       rs,
  output logic [$clog2(PHASES)-1:0]  phase_cnt,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       load_overrun
);

  localparam int unsigned PW = $clog2(PHASES);
  localparam int unsigned DW = $clog2(max_u(VNU_DELAY, CNU_DELAY) + 1);

  phase_state_t  state;
  logic [DW-1:0] drain_cnt;
  logic          pending;
  logic          consume;
  logic          last_phase;
  logic          run_end;
  logic          drain_zero;

  assign last_phase = (phase_cnt == PW'(PHASES - 1));
  assign run_end    = (sweep_addr == ADDR_WIDTH'(L - 1));
  assign drain_zero = (drain_cnt == '0);

  ldpc_frame_pending u_pending (
    .clk          (clk),
    .reset        (reset),
    .load_done    (load_done),
    .consume      (consume),
    .pending      (pending),
    .load_overrun (load_overrun)
  );

  // Decide whether this cycle takes a frame; end-of-frame and WAIT also
  // accept a load arriving in the same cycle so no bubble is inserted.
  always_comb begin
    consume = 1'b0;
    if (!abort) begin
      case (state)
        ST_IDLE:   consume = start & pending;
        ST_SWITCH: consume = last_phase & (pending | load_done);
        ST_WAIT:   consume = pending | load_done;
        default:   consume = 1'b0;
      endcase
    end
  end

  // Main FSM with registered controls; abort beats every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      enable     <= 1'b0;
      vnu_en     <= 1'b0;
      ag_reset   <= 1'b1;
      extended   <= 1'b0;
      sweep_addr <= '0;
      rs         <= 1'b0;
      phase_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        enable     <= 1'b0;
        vnu_en     <= 1'b0;
        ag_reset   <= 1'b1;
        extended   <= 1'b0;
        sweep_addr <= '0;
        phase_cnt  <= '0;
        busy       <= 1'b0;
        drain_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (consume) begin
              state      <= ST_RUN;
              rs         <= ~rs;
              vnu_en     <= 1'b1;
              phase_cnt  <= '0;
              sweep_addr <= '0;
              enable     <= 1'b1;
              ag_reset   <= 1'b0;
              extended   <= 1'b0;
              busy       <= 1'b1;
            end
          end
          ST_RUN: begin
            if (run_end) begin
              state     <= ST_DRAIN;
              extended  <= 1'b1;
              drain_cnt <= vnu_en ? DW'(VNU_DELAY - 1) : DW'(CNU_DELAY - 1);
            end else begin
              sweep_addr <= sweep_addr + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (drain_zero) begin
              state      <= ST_SWITCH;
              ag_reset   <= 1'b1;
              sweep_addr <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          ST_SWITCH: begin
            ag_reset <= 1'b0;
            extended <= 1'b0;
            if (!last_phase) begin
              state     <= ST_RUN;
              phase_cnt <= phase_cnt + 1'b1;
              vnu_en    <= ~vnu_en;
            end else begin
              frame_done <= 1'b1;
              phase_cnt  <= '0;
              vnu_en     <= 1'b1;
              if (consume) begin
                state <= ST_RUN;
                rs    <= ~rs;
              end else begin
                state    <= ST_WAIT;
                enable   <= 1'b0;
                ag_reset <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (consume) begin
              state    <= ST_RUN;
              rs       <= ~rs;
              enable   <= 1'b1;
              ag_reset <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
